// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used by both the FSM and its bench.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int MEM_INDEX_W_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // Reserved size 2'b11 is folded into the misaligned case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian byte-lane steering: extracts and extends a load lane, and merges
// a right-justified store value into a memory word.
module lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    // Offset 0 is the most significant lane, so the shift counts down.
    logic [4:0]        shift_b;
    logic [4:0]        shift_h;
    logic [DATA_W-1:0] lane_b_word;
    logic [DATA_W-1:0] lane_h_word;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [DATA_W-1:0] mask_b;
    logic [DATA_W-1:0] mask_h;

    assign shift_b     = {~offset, 3'b000};
    assign shift_h     = {~offset[1], 4'b0000};
    assign lane_b_word = mem_word >> shift_b;
    assign lane_h_word = mem_word >> shift_h;
    assign lane_b      = lane_b_word[7:0];
    assign lane_h      = lane_h_word[15:0];
    assign mask_b      = 32'h0000_00FF << shift_b;
    assign mask_h      = 32'h0000_FFFF << shift_h;

    always_comb begin
        load_data = mem_word;
        case (size)
            SIZE_BYTE: load_data = is_signed ? {{(DATA_W-8){lane_b[7]}}, lane_b}
                                             : {{(DATA_W-8){1'b0}}, lane_b};
            SIZE_HALF: load_data = is_signed ? {{(DATA_W-16){lane_h[15]}}, lane_h}
                                             : {{(DATA_W-16){1'b0}}, lane_h};
            default:   load_data = mem_word;
        endcase
    end

    always_comb begin
        merged = store_data;
        case (size)
            SIZE_BYTE: merged = (mem_word & ~mask_b)
                              | ({{(DATA_W-8){1'b0}}, store_data[7:0]} << shift_b);
            SIZE_HALF: merged = (mem_word & ~mask_h)
                              | ({{(DATA_W-16){1'b0}}, store_data[15:0]} << shift_h);
            default:   merged = store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit driving the word-indexed data port of the unified
// memory; sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_INDEX_W = MEM_INDEX_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic [ADDR_W-1:0] dataMemoryAddress,
    output logic              dataMemorywriteEnable,
    output logic [DATA_W-1:0] dataMemorydataIn,
    input  logic [DATA_W-1:0] dataMemorydataOut
);

    state_t                 state, state_next;
    logic                   accept;
    logic                   req_bad;
    logic [1:0]             size_q;
    logic [1:0]             offset_q;
    logic                   signed_q;
    logic                   misaligned_q;
    logic [MEM_INDEX_W-1:0] index_q;
    logic [DATA_W-1:0]      word_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [DATA_W-1:0]      load_data;
    logic [DATA_W-1:0]      merged;
    logic                   unused_addr_hi;

    // Address bits above the index alias away by design.
    assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_INDEX_W+2];

    assign accept  = req_valid && (state == ST_IDLE);
    assign req_bad = is_misaligned(req_size, req_addr[1:0]);

    lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size       (size_q),
        .offset     (offset_q),
        .is_signed  (signed_q),
        .mem_word   (dataMemorydataOut),
        .store_data (word_q),
        .load_data  (load_data),
        .merged     (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad)                    state_next = ST_RESP;
                    else if (!req_write)            state_next = ST_LOAD;
                    else if (req_size == SIZE_WORD) state_next = ST_WRITE;
                    else                            state_next = ST_RMW_READ;
                end
            end
            ST_LOAD:     state_next = ST_RESP;
            ST_RMW_READ: state_next = ST_WRITE;
            ST_WRITE:    state_next = ST_RESP;
            ST_RESP:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready             = (state == ST_IDLE);
        resp_valid            = (state == ST_RESP);
        resp_rdata            = (state == ST_RESP) ? rdata_q : '0;
        resp_misaligned       = (state == ST_RESP) && misaligned_q;
        dataMemorywriteEnable = (state == ST_WRITE);
        dataMemorydataIn      = (state == ST_WRITE) ? word_q : '0;
        dataMemoryAddress     = {{(ADDR_W-MEM_INDEX_W){1'b0}}, index_q};
    end

    // word_q holds the store data until RMW_READ replaces it with the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q       <= '0;
            offset_q     <= '0;
            signed_q     <= 1'b0;
            misaligned_q <= 1'b0;
            index_q      <= '0;
            word_q       <= '0;
            rdata_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_q       <= req_size;
                        offset_q     <= req_addr[1:0];
                        signed_q     <= req_signed;
                        misaligned_q <= req_bad;
                        index_q      <= req_addr[MEM_INDEX_W+1:2];
                        word_q       <= req_wdata;
                        rdata_q      <= '0;
                    end
                end
                ST_LOAD:     rdata_q <= load_data;
                ST_RMW_READ: word_q  <= merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word memory as
// the responder on the data port.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] dataMemoryAddress;
    logic        dataMemorywriteEnable;
    logic [31:0] dataMemorydataIn;
    logic [31:0] dataMemorydataOut;

    logic [31:0] mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_waddr;
    logic [31:0] tb_wdata;
    int          wr_pulses = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_write             (req_write),
        .req_size              (req_size),
        .req_signed            (req_signed),
        .req_addr              (req_addr),
        .req_wdata             (req_wdata),
        .resp_valid            (resp_valid),
        .resp_rdata            (resp_rdata),
        .resp_misaligned       (resp_misaligned),
        .dataMemoryAddress     (dataMemoryAddress),
        .dataMemorywriteEnable (dataMemorywriteEnable),
        .dataMemorydataIn      (dataMemorydataIn),
        .dataMemorydataOut     (dataMemorydataOut)
    );

    assign dataMemorydataOut = mem[dataMemoryAddress[7:0]];

    always @(posedge clk) begin
        if (dataMemorywriteEnable) mem[dataMemoryAddress[7:0]] <= dataMemorydataIn;
        else if (tb_we)            mem[tb_waddr] <= tb_wdata;
    end

    always @(posedge clk) begin
        if (dataMemorywriteEnable) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        tb_we    = 1'b1;
        tb_waddr = idx;
        tb_wdata = val;
        @(posedge clk); #1;
        tb_we    = 1'b0;
    endtask

    // Issues one request from IDLE, returns latency in edges counted from the
    // accepting edge, the response fields and the number of write pulses.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd,
                           output logic mis, output int pulses);
        int p0;
        p0         = wr_pulses;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_wdata  = 32'hDEAD_BEEF;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd     = resp_rdata;
        mis    = resp_misaligned;
        @(posedge clk); #1;
        pulses = wr_pulses - p0;
    endtask

    int          lat;
    int          pulses;
    logic [31:0] rd;
    logic        mis;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        tb_we      = 1'b0;
        tb_waddr   = '0;
        tb_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst we", {31'b0, dataMemorywriteEnable}, 32'd0);
        check("rst addr", dataMemoryAddress, 32'd0);
        check("rst dataIn", dataMemorydataIn, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store
        preload(8'h10, 32'h0);
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h1122_3344, lat, rd, mis, pulses);
        check("sw lat", lat, 2);
        check("sw rdata", rd, 32'h0);
        check("sw pulses", pulses, 1);
        check("sw mem", mem[8'h10], 32'h1122_3344);

        // Loads with sign/zero extension
        preload(8'h10, 32'h80FF_7F01);
        run_req(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, lat, rd, mis, pulses);
        check("lb data", rd, 32'hFFFF_FF80);
        check("lb lat", lat, 2);
        run_req(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat, rd, mis, pulses);
        check("lbu data", rd, 32'h0000_0080);
        run_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, lat, rd, mis, pulses);
        check("lh data", rd, 32'hFFFF_80FF);
        check("lh lat", lat, 2);
        run_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, lat, rd, mis, pulses);
        check("lhu data", rd, 32'h0000_7F01);
        run_req(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, lat, rd, mis, pulses);
        check("lb3 data", rd, 32'h0000_0001);

        // Sub-word stores via read-modify-write
        preload(8'h10, 32'h1122_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56AB, lat, rd, mis, pulses);
        check("sb lat", lat, 3);
        check("sb pulses", pulses, 1);
        check("sb mem", mem[8'h10], 32'h11AB_3344);
        run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF, lat, rd, mis, pulses);
        check("sh lat", lat, 3);
        check("sh mem", mem[8'h10], 32'h11AB_BEEF);
        check("sh rdata", rd, 32'h0);

        // Misaligned and reserved-size requests
        run_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, mis, pulses);
        check("lw mis flag", {31'b0, mis}, 32'd1);
        check("lw mis lat", lat, 1);
        check("lw mis rdata", rd, 32'h0);
        run_req(1'b1, 2'b01, 1'b0, 32'h43, 32'h0000_5555, lat, rd, mis, pulses);
        check("sh mis flag", {31'b0, mis}, 32'd1);
        check("sh mis lat", lat, 1);
        check("sh mis pulses", pulses, 0);
        run_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h0000_5555, lat, rd, mis, pulses);
        check("rsv mis flag", {31'b0, mis}, 32'd1);
        check("rsv pulses", pulses, 0);
        check("mis mem", mem[8'h10], 32'h11AB_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, mis, pulses);
        check("lw ok flag", {31'b0, mis}, 32'd0);
        check("lw ok data", rd, 32'h11AB_BEEF);

        // Reset while an RMW is in flight
        preload(8'h10, 32'h1122_3344);
        pulses     = wr_pulses;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_addr   = 32'h40;
        req_wdata  = 32'h0000_00AB;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("mid-rst we", {31'b0, dataMemorywriteEnable}, 32'd0);
        check("mid-rst resp", {31'b0, resp_valid}, 32'd0);
        check("mid-rst addr", dataMemoryAddress, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid-rst pulses", wr_pulses - pulses, 0);
        check("mid-rst mem", mem[8'h10], 32'h1122_3344);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-rst ready", {31'b0, req_ready}, 32'd1);
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, mis, pulses);
        check("post-rst lw", rd, 32'h1122_3344);

        // Back-to-back loads with req_valid held
        preload(8'h00, 32'hA5A5_0001);
        preload(8'h01, 32'h5A5A_0002);
        begin
            int          cyc;
            int          n_acc;
            int          n_resp;
            int          acc_cyc [0:1];
            int          resp_cyc [0:1];
            logic [31:0] resp_dat [0:1];
            logic        acc;
            cyc    = 0;
            n_acc  = 0;
            n_resp = 0;
            acc_cyc  = '{-1, -1};
            resp_cyc = '{-1, -1};
            resp_dat = '{32'h0, 32'h0};
            req_valid = 1'b1;
            req_write = 1'b0;
            req_size  = 2'b10;
            req_addr  = 32'h0;
            for (int i = 0; i < 20; i++) begin
                acc = req_valid && req_ready;
                if (acc && n_acc < 2) begin
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    if (n_acc == 1) req_addr = 32'h4;
                    else            req_valid = 1'b0;
                end
                if (resp_valid && n_resp < 2) begin
                    resp_cyc[n_resp] = cyc;
                    resp_dat[n_resp] = resp_rdata;
                    n_resp++;
                end
                if (n_resp == 2) break;
            end
            req_valid = 1'b0;
            check("b2b resp count", n_resp, 2);
            check("b2b data0", resp_dat[0], 32'hA5A5_0001);
            check("b2b data1", resp_dat[1], 32'h5A5A_0002);
            check("b2b resp0 lat", resp_cyc[0] - acc_cyc[0], 2);
            check("b2b accept1", acc_cyc[1], resp_cyc[0] + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit that drives the data port of the unified word memory (`memory` block) on behalf of the CPU pipeline.
- Accepts byte, halfword and word loads and stores at byte addresses, using big-endian MIPS lane order.
- Stores narrower than a word are done as read-modify-write over the word-wide memory port.
- Loads return sign- or zero-extended results; misaligned requests are reported as errors and never reach memory.

Parameters:
- ADDR_W, 32, width of CPU byte address and memory address ports
- DATA_W, 32, data width; fixed at 32 (lane logic assumes 4 bytes)
- MEM_INDEX_W, 15, significant word-index bits presented to memory

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as misaligned)
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid; request was rejected
- dataMemoryAddress  out  ADDR_W  word index = {zeros, addr[MEM_INDEX_W+1:2]}
- dataMemorywriteEnable  out  1  memory write strobe
- dataMemorydataIn  out  DATA_W  word to write
- dataMemorydataOut  in  DATA_W  combinational read data for dataMemoryAddress

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - All outputs go to 0, except req_ready, which is 1 once in IDLE.
  - dataMemorywriteEnable is decoded from state, so it drops immediately.
- Memory contract: the read is combinational in the same cycle; the write commits on the rising edge while the write enable is high. The data port is word-indexed, so byte address bits [1:0] never reach memory.
- Byte lanes: byte offset 0 maps to [31:24] and offset 3 to [7:0]. Halfword offset 0 maps to [31:16] and offset 2 to [15:0].
- Alignment errors: a halfword with addr[0]=1, a word with addr[1:0]≠0, or size 11.
- Handshake:
  - A request is accepted when req_valid && req_ready. req_ready=1 only in IDLE.
  - Request fields are captured into registers on accept; CPU inputs are ignored afterwards.
  - One outstanding request at a time.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
  - IDLE: on accept, go to RESP with the error flag set if misaligned, else LOAD if it is a load, WRITE if it is a word store, RMW_READ if it is a sub-word store.
  - LOAD: drive the address, extract and extend the lane from dataMemorydataOut, register it into resp_rdata, then go to RESP.
  - RMW_READ: drive the address, merge the store lane into dataMemorydataOut, register the merged word, then go to WRITE.
  - WRITE: drive the address and dataMemorydataIn = merged word (or req_wdata for word stores) with dataMemorywriteEnable=1 for exactly this cycle, then go to RESP.
  - RESP: resp_valid=1 with resp_rdata and resp_misaligned held from registers, then go to IDLE.
- Latency, accept at edge T (resp_valid high in cycle T+n):
  - misaligned: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Throughput: the next request is acceptable in the cycle after resp_valid, so accept-to-accept is latency+1.
- dataMemoryAddress holds the last captured index outside active states. dataMemorydataIn is 0 except in WRITE.
- Misaligned requests and reserved sizes never assert dataMemorywriteEnable.
- Reset mid-operation: any in-flight access is abandoned and no write occurs after rst_n falls. The partial RMW merged word is discarded.
- Address wrap: bits above MEM_INDEX_W+1 are dropped, so addresses alias modulo 2^(MEM_INDEX_W+2) bytes.

Decomposition:
- Shared package (mem_pkg): SIZE_BYTE/HALF/WORD encodings, FSM state encodings, MEM_INDEX_W default.
- One sub-module, lane_align (combinational). Inputs are size, offset and signed. It performs load lane extraction/extension and store lane merge.
- FSM and registers stay in mem_access_unit.

Test Plan:
- The bench instantiates `memory` as the responder.
1. sw 0x11223344 @0x40 → write enable high for one cycle, mem[0x10]=0x11223344, resp_valid at T+2, resp_rdata=0.
2. Preload mem[0x10]=0x80FF7F01, then:
   - lb @0x40 → 0xFFFFFF80
   - lbu @0x40 → 0x00000080
   - lh @0x40 → 0xFFFF80FF
   - lhu @0x42 → 0x00007F01
   - each resp at T+2
3. From mem[0x10]=0x11223344:
   - sb 0xAB @0x41 → 0x11AB3344, resp at T+3, one write pulse
   - then sh 0xBEEF @0x42 → 0x11ABBEEF
4. lw @0x42 and sh @0x43 → resp_misaligned=1 at T+1, resp_rdata=0, write enable never high, memory unchanged.
5. Drop rst_n during RMW_READ of sb @0x40 → write enable stays 0, mem[0x10] unchanged, outputs zero. After release, req_ready=1 and a following lw returns the original word.
6. req_valid held high with back-to-back lw @0x0, @0x4 → second accept occurs the cycle after the first resp_valid, with correct data for each.
